fifo_access_scheduler: RTL

//  Shares the 32-bit FIFO_BUFFER_MEMORY between NUM_PROD producers (round-robin write arbitration)
//  and one consumer (pop/valid). Sole driver of the FIFO's enable/reset/read/write/data_in.

---
 rtl/fifo_sched_pkg.sv | 10 +
 rtl/fifo_access_scheduler_if.sv | 22 ++
 rtl/fifo_access_scheduler_rr_arbiter.sv | 30 +++
 rtl/fifo_access_scheduler.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared state encoding and default sizes for the FIFO access scheduler
package fifo_sched_pkg;
    typedef enum logic {
        S_FLUSH = 1'b0,
        S_RUN   = 1'b1
    } sched_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;
endpackage

// File: rtl/fifo_access_scheduler_if.sv
// rtl/fifo_access_scheduler_if.sv - control/data bus between the scheduler and FIFO_BUFFER_MEMORY
interface fifo_access_scheduler_if import fifo_sched_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);
    logic              fifo_enable;
    logic              fifo_reset;
    logic              fifo_write;
    logic              fifo_read;
    logic [DATA_W-1:0] fifo_data_in;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_empty;

    modport master (
        output fifo_enable, fifo_reset, fifo_write, fifo_read, fifo_data_in,
        input  fifo_data_out, fifo_empty
    );

    modport slave (
        input  fifo_enable, fifo_reset, fifo_write, fifo_read, fifo_data_in,
        output fifo_data_out, fifo_empty
    );
endinterface

// File: rtl/fifo_access_scheduler_rr_arbiter.sv
// rtl/fifo_access_scheduler_rr_arbiter.sv - combinational round-robin pick of the first requester at or after i_ptr
module rr_arbiter #(
    parameter  int NUM_PROD = 4,
    localparam int PW       = $clog2(NUM_PROD)
) (
    input  logic [NUM_PROD-1:0] i_req,
    input  logic [PW-1:0]       i_ptr,
    output logic [NUM_PROD-1:0] o_gnt,
    output logic [PW-1:0]       o_idx,
    output logic                o_any
);
    int w_idx;

    // Scan from farthest to nearest so the nearest requester to i_ptr is the last assignment.
    always_comb begin
        w_idx = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = |i_req;
        for (int i = NUM_PROD - 1; i >= 0; i--) begin
            w_idx = (int'(i_ptr) + i) % NUM_PROD;
            if (i_req[w_idx[PW-1:0]]) begin
                o_idx = PW'(w_idx);
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/fifo_access_scheduler.sv
// rtl/fifo_access_scheduler.sv - arbitrates producers and one consumer onto a single FIFO, tracking occupancy
module fifo_access_scheduler import fifo_sched_pkg::*; #(
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int DEPTH        = DEF_DEPTH,
    parameter  int NUM_PROD     = 4,
    parameter  int FLUSH_CYCLES = 2,
    parameter  int MAX_RD_BURST = 4,
    parameter  int READ_LAT     = 1,
    localparam int LW           = $clog2(DEPTH) + 1,
    localparam int PW           = $clog2(NUM_PROD),
    localparam int BW           = $clog2(MAX_RD_BURST + 1),
    localparam int FW           = $clog2(FLUSH_CYCLES) + 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [NUM_PROD-1:0]        prod_req,
    input  logic [NUM_PROD*DATA_W-1:0] prod_data,
    output logic [NUM_PROD-1:0]        prod_gnt,
    input  logic                       cons_pop,
    output logic                       cons_pop_ack,
    output logic                       cons_valid,
    output logic [DATA_W-1:0]          cons_data,
    output logic [LW-1:0]              level,
    output logic                       full,
    output logic                       sync_err,
    fifo_access_scheduler_if.master    fifo
);
    sched_state_t          r_state, w_state_nx;
    logic [LW-1:0]         r_level;
    logic [PW-1:0]         r_rr_ptr;
    logic [BW-1:0]         r_rd_burst;
    logic [FW-1:0]         r_flush_cnt;
    logic [READ_LAT-1:0]   r_vpipe;
    logic                  r_sync_err;
    logic                  r_quiet;

    logic [NUM_PROD-1:0]   w_gnt;
    logic [PW-1:0]         w_idx;
    logic                  w_any;
    logic                  w_rd_ok, w_wr_ok, w_do_rd, w_do_wr, w_flush_done;

    rr_arbiter #(.NUM_PROD(NUM_PROD)) u_arb (
        .i_req (prod_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // One FIFO access per cycle; a full burst of reads yields a slot to a waiting writer.
    always_comb begin
        w_state_nx   = r_state;
        w_do_rd      = 1'b0;
        w_do_wr      = 1'b0;
        w_rd_ok      = cons_pop && (r_level != '0);
        w_wr_ok      = w_any && (r_level != LW'(DEPTH));
        w_flush_done = (r_flush_cnt == FW'(FLUSH_CYCLES - 1));
        case (r_state)
            S_FLUSH: if (w_flush_done) w_state_nx = S_RUN;
            S_RUN: begin
                if (flush) begin
                    w_state_nx = S_FLUSH;
                end else if (w_rd_ok && !(w_wr_ok && r_rd_burst == BW'(MAX_RD_BURST))) begin
                    w_do_rd = 1'b1;
                end else if (w_wr_ok) begin
                    w_do_wr = 1'b1;
                end
            end
            default: w_state_nx = S_FLUSH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_FLUSH;
            r_level     <= '0;
            r_rr_ptr    <= '0;
            r_rd_burst  <= '0;
            r_flush_cnt <= '0;
            r_vpipe     <= '0;
            r_sync_err  <= 1'b0;
            r_quiet     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= w_flush_done ? '0 : r_flush_cnt + 1'b1;
            end else if (flush) begin
                r_flush_cnt <= '0;
                r_level     <= '0;
                r_rd_burst  <= '0;
                r_vpipe     <= '0;
                r_sync_err  <= 1'b0;
                r_quiet     <= 1'b0;
            end else begin
                r_vpipe[0] <= w_do_rd;
                for (int i = 1; i < READ_LAT; i++) begin
                    r_vpipe[i] <= r_vpipe[i-1];
                end
                if (w_do_rd) begin
                    r_level    <= r_level - 1'b1;
                    r_rd_burst <= (r_rd_burst == BW'(MAX_RD_BURST)) ? r_rd_burst : r_rd_burst + 1'b1;
                end else if (w_do_wr) begin
                    r_level    <= r_level + 1'b1;
                    r_rd_burst <= '0;
                    r_rr_ptr   <= (w_idx == PW'(NUM_PROD - 1)) ? '0 : w_idx + 1'b1;
                end else if (!w_any) begin
                    r_rd_burst <= '0;
                end
                r_quiet <= !(w_do_rd || w_do_wr);
                // Only compare once the FIFO has had a full idle cycle to settle its flag.
                if (r_quiet && !w_do_rd && !w_do_wr && ((r_level == '0) != fifo.fifo_empty)) begin
                    r_sync_err <= 1'b1;
                end
            end
        end
    end

    assign fifo.fifo_enable  = 1'b1;
    assign fifo.fifo_reset   = (r_state == S_FLUSH);
    assign fifo.fifo_read    = w_do_rd;
    assign fifo.fifo_write   = w_do_wr;
    assign fifo.fifo_data_in = w_do_wr ? prod_data[int'(w_idx)*DATA_W +: DATA_W] : '0;

    assign prod_gnt     = w_do_wr ? w_gnt : '0;
    assign cons_pop_ack = w_do_rd;
    assign cons_valid   = r_vpipe[READ_LAT-1] && (r_state == S_RUN) && !flush;
    assign cons_data    = fifo.fifo_data_out;
    assign level        = r_level;
    assign full         = (r_level == LW'(DEPTH));
    assign sync_err     = r_sync_err;
endmodule
